// File: rtl/enc_pkg.sv
// Shared definitions for the encoder input conditioning path.
package enc_pkg;

    // Channel bit map on the encoder connector
    localparam int unsigned CH_A0    = 0;
    localparam int unsigned CH_A1    = 1;
    localparam int unsigned CH_Z0    = 2;
    localparam int unsigned CH_Z1    = 3;
    localparam int unsigned N_CH_DEF = 4;

    // Width of a counter that must hold values up to filt_len-1 (never below 1 bit)
    function automatic int unsigned filt_cnt_w(input int unsigned filt_len);
        return (filt_len <= 2) ? 1 : $clog2(filt_len);
    endfunction

endpackage

// File: rtl/enc_filt_ch.sv
// Single encoder channel: synchroniser, persistence filter, edge strobes, glitch counter.
module enc_filt_ch
    import enc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned GCNT_W      = 16
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_raw,
    input  logic              i_bypass,
    input  logic              i_clr_glitch,
    output logic              o_lvl,
    output logic              o_rise,
    output logic              o_fall,
    output logic [GCNT_W-1:0] o_glitch_cnt,
    output logic              o_glitch_c
);

    localparam int unsigned      CNT_W   = filt_cnt_w(FILT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_lvl;
    logic                   w_lvl_nxt;
    logic                   w_glitch;
    logic                   r_rise;
    logic                   r_fall;
    logic [GCNT_W-1:0]      r_gcnt;

    // Shift the asynchronous pin through the synchroniser chain
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Filter decision: accept a new level only after it persists FILT_LEN edges
    always_comb begin
        w_lvl_nxt = r_lvl;
        w_cnt_nxt = r_cnt;
        w_glitch  = 1'b0;
        if (i_bypass) begin
            w_lvl_nxt = w_sync;
            w_cnt_nxt = '0;
        end else if (w_sync != r_lvl) begin
            if (r_cnt == CNT_MAX) begin
                w_lvl_nxt = ~r_lvl;
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end else if (r_cnt != '0) begin
            // Candidate level vanished before being accepted
            w_cnt_nxt = '0;
            w_glitch  = 1'b1;
        end
    end

    // Filter state and strobes; strobes align with the first cycle of the new level
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_lvl  <= 1'b0;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_lvl  <= w_lvl_nxt;
            r_cnt  <= w_cnt_nxt;
            r_rise <= w_lvl_nxt & ~r_lvl;
            r_fall <= ~w_lvl_nxt & r_lvl;
        end
    end

    // Saturating glitch counter; clear has priority over a same-cycle glitch
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_gcnt <= '0;
        end else if (i_clr_glitch) begin
            r_gcnt <= '0;
        end else if (w_glitch && (r_gcnt != '1)) begin
            r_gcnt <= r_gcnt + GCNT_W'(1);
        end
    end

    assign o_lvl        = r_lvl;
    assign o_rise       = r_rise;
    assign o_fall       = r_fall;
    assign o_glitch_cnt = r_gcnt;
    assign o_glitch_c   = w_glitch;

endmodule

// File: rtl/enc_input_cond.sv
// Encoder input conditioner: N_CH independent filtered channels plus a sticky glitch flag.
module enc_input_cond
    import enc_pkg::*;
#(
    parameter int unsigned N_CH        = N_CH_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned GCNT_W      = 16
) (
    input  logic                   CLK,
    input  logic                   I_RST,
    input  logic [N_CH-1:0]        I_RAW,
    input  logic                   I_BYPASS,
    input  logic                   I_CLR_GLITCH,
    output logic [N_CH-1:0]        O_LVL,
    output logic [N_CH-1:0]        O_RISE,
    output logic [N_CH-1:0]        O_FALL,
    output logic [N_CH*GCNT_W-1:0] O_GLITCH_CNT,
    output logic                   O_GLITCH_ANY
);

    logic [N_CH-1:0] w_glitch;
    logic            r_glitch_any;

    // One conditioning slice per encoder pin
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        enc_filt_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN),
            .GCNT_W      (GCNT_W)
        ) u_ch (
            .clk          (CLK),
            .i_rst        (I_RST),
            .i_raw        (I_RAW[g]),
            .i_bypass     (I_BYPASS),
            .i_clr_glitch (I_CLR_GLITCH),
            .o_lvl        (O_LVL[g]),
            .o_rise       (O_RISE[g]),
            .o_fall       (O_FALL[g]),
            .o_glitch_cnt (O_GLITCH_CNT[g*GCNT_W +: GCNT_W]),
            .o_glitch_c   (w_glitch[g])
        );
    end

    // Sticky interrupt flag: set by any channel's glitch, cleared by clear or reset
    always_ff @(posedge CLK) begin
        if (I_RST) begin
            r_glitch_any <= 1'b0;
        end else if (I_CLR_GLITCH) begin
            r_glitch_any <= 1'b0;
        end else if (|w_glitch) begin
            r_glitch_any <= 1'b1;
        end
    end

    assign O_GLITCH_ANY = r_glitch_any;

endmodule

// File: doc/enc_input_cond.md
Name: enc_input_cond

Overview:
- Input conditioner for the raw quadrature/index lines (A0, A1, Z0, Z1) coming from the encoder connector.
- Sits directly upstream of the encoder top level (mux + counters) and feeds it clean, clock-aligned levels.
- Per channel it does three things:
  - synchronises the asynchronous pin into CLK;
  - rejects pulses shorter than a programmable length;
  - emits single-cycle rise/fall strobes and counts rejected glitches for diagnostics over AXI.

Parameters:
- N_CH, 4, number of channels; bit map 0=A0, 1=A1, 2=Z0, 3=Z1.
- SYNC_STAGES, 2, synchroniser flop depth (>=2).
- FILT_LEN, 4, consecutive cycles a new level must persist to be accepted (>=1).
- GCNT_W, 16, width of each per-channel glitch counter.

Ports:
- CLK  in  1  system clock, same as the counter stage.
- I_RST  in  1  synchronous, active-high reset.
- I_RAW  in  N_CH  raw asynchronous encoder pins.
- I_BYPASS  in  1  1 = skip glitch filter (sync only).
- I_CLR_GLITCH  in  1  single-cycle clear of glitch counters and sticky flag.
- O_LVL  out  N_CH  filtered level, to counter stage A/Z inputs.
- O_RISE  out  N_CH  1-cycle strobe on O_LVL 0->1.
- O_FALL  out  N_CH  1-cycle strobe on O_LVL 1->0.
- O_GLITCH_CNT  out  N_CH*GCNT_W  rejected-pulse counts; channel i at [i*GCNT_W +: GCNT_W].
- O_GLITCH_ANY  out  1  sticky: any glitch since last clear/reset (interrupt source).

Behaviour:
- Reset (I_RST=1 at an edge):
  - clears all sync flops, filter counters, O_LVL, O_RISE, O_FALL, O_GLITCH_CNT and O_GLITCH_ANY to 0;
  - the reset wins over every other input in that cycle.
- Synchroniser: SYNC_STAGES-deep shift per channel; only the last stage (sync_i) is used downstream.
- Filter, per channel, state = {lvl, cnt}; cnt is wide enough for FILT_LEN-1. Each edge, with I_BYPASS=0:
  - sync_i != lvl and cnt == FILT_LEN-1: toggle lvl, cnt <= 0.
  - sync_i != lvl otherwise: cnt <= cnt+1.
  - sync_i == lvl and cnt != 0: cnt <= 0 and a glitch event is recorded.
  - sync_i == lvl and cnt == 0: hold.
- Latency:
  - A raw change set up before edge 1 appears on O_LVL after edge SYNC_STAGES+FILT_LEN (default: 6).
  - A raw pulse shorter than FILT_LEN cycles never reaches O_LVL.
- FILT_LEN=1: lvl follows sync_i one cycle later; glitch events are impossible.
- O_RISE/O_FALL:
  - registered, asserted in exactly the cycle O_LVL first shows the new value, for one cycle;
  - never both high on one channel.
- Bypass (I_BYPASS=1):
  - lvl <= sync_i every edge; cnt forced to 0; no glitch events; strobes still generated.
  - Toggling I_BYPASS in either direction never produces a spurious strobe: lvl is continuous and a strobe occurs only when lvl actually changes.
- Glitch counter (per channel):
  - increments by 1 per glitch event;
  - saturates at all-ones and does not wrap;
  - I_CLR_GLITCH=1 zeroes all counters and O_GLITCH_ANY. Clear wins over a simultaneous increment: the result is 0 and the flag stays 0.
- O_GLITCH_ANY: set on any channel's glitch event; stays set until clear or reset.
- Post-reset: if a raw pin is already high, O_LVL rises after the normal latency and a single O_RISE is produced. The downstream counter stage is expected to be armed only after this settles.
- Channels are fully independent; simultaneous events on several channels are handled in parallel.

Decomposition:
- Shared package enc_pkg holds:
  - localparams for the channel index map (CH_A0=0, CH_A1=1, CH_Z0=2, CH_Z1=3);
  - N_CH default;
  - a clog2-based width helper for the filter counter.
- One natural sub-module, enc_filt_ch: a single-channel synchroniser + filter + strobe + glitch counter, instantiated N_CH times by a generate loop.
- The top level only ORs the per-channel glitch events into O_GLITCH_ANY.

Test Plan:
- Reset with I_RAW=4'b0000, then I_RAW[0] 0->1 held → O_LVL[0]=1 after edge 6; O_RISE[0]=1 for exactly that one cycle; O_GLITCH_CNT all 0.
- I_RAW[1] high for 2 cycles, then low (FILT_LEN=4) → O_LVL[1] stays 0; channel-1 count=1; O_GLITCH_ANY=1; no strobe.
- Glitch counter saturation (GCNT_W=4), 20 short pulses on channel 2 → count saturates at 15; then I_CLR_GLITCH coinciding with a glitch event → count=0 and O_GLITCH_ANY=0.
- I_BYPASS=1 with a 1-cycle pulse on I_RAW[3] → O_LVL[3] high for 1 cycle starting after edge SYNC_STAGES+1; one O_RISE and one O_FALL; glitch count stays 0.
- Reset mid-operation: assert I_RST while channel 0's filter cnt=2 and a glitch count is nonzero → all outputs 0 on the next cycle; after release, normal latency resumes from the initial state.
- All four inputs toggle simultaneously every 10 cycles → each O_LVL bit tracks its input with a 6-cycle delay; 4 strobes per transition; no glitches.
